// File: rtl/tea_key_loader.sv
// tea_key_loader
//   Assembles a 128-bit TEA key from a byte stream and presents it as four
//   32-bit round-key words. The key is frozen while an encryption runs
//   (i_calculate high while a full key is held).
//
//   Optional feature macro: TEA_KEY_CHECKSUM_EN
//     When defined, a 17th byte (XOR of the 16 key bytes) must follow the key
//     before it is declared valid; a mismatch discards the key and pulses
//     o_checksum_err for one cycle.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst_n            synchronous active-low reset
//   i_key_byte         key byte
//   i_key_byte_valid   i_key_byte presented this cycle
//   i_key_clear        synchronous clear request (ignored while locked)
//   i_calculate        encryptor run request
//   o_round_key_data   key words, byte k at word k/4, bits 8*(k%4) +: 8
//   o_round_key_valid  full key present
//   o_key_ready        a presented byte will be accepted
//   o_byte_count       bytes accepted into the current key (0..16)
//   o_overrun          sticky: a byte was dropped while locked
//   o_checksum_err     one-cycle checksum mismatch pulse (0 without macro)
module tea_key_loader #(
  parameter bit          CLEAR_ON_RELOAD = 1'b1,
  parameter int unsigned KEY_BYTES       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_key_byte,
  input  logic             i_key_byte_valid,
  input  logic             i_key_clear,
  input  logic             i_calculate,
  output logic [3:0][31:0] o_round_key_data,
  output logic             o_round_key_valid,
  output logic             o_key_ready,
  output logic [4:0]       o_byte_count,
  output logic             o_overrun,
  output logic             o_checksum_err
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_LOADING,
    S_VALID,
    S_LOCKED
`ifdef TEA_KEY_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t       r_state, w_state_n;
  logic [127:0] r_key, w_key_n;
  logic [4:0]   r_count, w_count_n;
  logic         r_overrun, w_overrun_n;
  // Running XOR of the bytes of the key being loaded.
  logic [7:0]   r_xor, w_xor_n;
  logic [3:0]   w_idx;
  logic         w_last;

  assign w_idx  = r_count[3:0];
  assign w_last = (r_count == 5'(KEY_BYTES - 1));

`ifdef TEA_KEY_CHECKSUM_EN
  logic r_err, w_err_n;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_EMPTY;
      r_key     <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_xor     <= '0;
`ifdef TEA_KEY_CHECKSUM_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_key     <= w_key_n;
      r_count   <= w_count_n;
      r_overrun <= w_overrun_n;
      r_xor     <= w_xor_n;
`ifdef TEA_KEY_CHECKSUM_EN
      r_err     <= w_err_n;
`endif
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_key_n     = r_key;
    w_count_n   = r_count;
    w_overrun_n = r_overrun;
    w_xor_n     = r_xor;
`ifdef TEA_KEY_CHECKSUM_EN
    w_err_n     = 1'b0;
`endif

    if (r_state == S_LOCKED) begin
      // Clear is ignored here; only release of i_calculate leaves.
      if (i_key_byte_valid) w_overrun_n = 1'b1;
      if (!i_calculate)     w_state_n   = S_VALID;
    end else if (i_key_clear) begin
      w_state_n   = S_EMPTY;
      w_key_n     = '0;
      w_count_n   = '0;
      w_overrun_n = 1'b0;
      w_xor_n     = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_key_byte_valid) begin
            w_key_n[7:0] = i_key_byte;
            w_count_n    = 5'd1;
            w_xor_n      = i_key_byte;
            w_state_n    = S_LOADING;
          end
        end
        S_LOADING: begin
          if (i_key_byte_valid) begin
            w_key_n[{w_idx, 3'b000} +: 8] = i_key_byte;
            w_count_n = r_count + 5'd1;
            w_xor_n   = r_xor ^ i_key_byte;
            if (w_last) begin
`ifdef TEA_KEY_CHECKSUM_EN
              w_state_n = S_CHECK;
`else
              w_state_n = S_VALID;
`endif
            end
          end
        end
        S_VALID: begin
          if (i_calculate) begin
            w_state_n = S_LOCKED;
            if (i_key_byte_valid) w_overrun_n = 1'b1;
          end else if (i_key_byte_valid) begin
            if (CLEAR_ON_RELOAD) w_key_n = '0;
            w_key_n[7:0] = i_key_byte;
            w_count_n    = 5'd1;
            w_xor_n      = i_key_byte;
            w_state_n    = S_LOADING;
          end
        end
`ifdef TEA_KEY_CHECKSUM_EN
        S_CHECK: begin
          if (i_key_byte_valid) begin
            if (i_key_byte == r_xor) begin
              w_state_n = S_VALID;
            end else begin
              w_state_n = S_EMPTY;
              w_key_n   = '0;
              w_count_n = '0;
              w_xor_n   = '0;
              w_err_n   = 1'b1;
            end
          end
        end
`endif
        default: w_state_n = S_EMPTY;
      endcase
    end
  end

  assign o_round_key_data  = r_key;
  assign o_round_key_valid = (r_state == S_VALID) || (r_state == S_LOCKED);
  assign o_key_ready       = (r_state != S_LOCKED);
  assign o_byte_count      = r_count;
  assign o_overrun         = r_overrun;
`ifdef TEA_KEY_CHECKSUM_EN
  assign o_checksum_err    = r_err;
`else
  assign o_checksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tea_key_loader.sv
module tb_tea_key_loader;
  localparam bit          CLR = 1'b1;
  localparam int unsigned NB  = 16;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic [7:0]       i_key_byte;
  logic             i_key_byte_valid;
  logic             i_key_clear;
  logic             i_calculate;
  logic [3:0][31:0] o_round_key_data;
  logic             o_round_key_valid;
  logic             o_key_ready;
  logic [4:0]       o_byte_count;
  logic             o_overrun;
  logic             o_checksum_err;

  always #5 i_clk = ~i_clk;

  tea_key_loader #(.CLEAR_ON_RELOAD(CLR), .KEY_BYTES(NB)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_key_byte       (i_key_byte),
    .i_key_byte_valid (i_key_byte_valid),
    .i_key_clear      (i_key_clear),
    .i_calculate      (i_calculate),
    .o_round_key_data (o_round_key_data),
    .o_round_key_valid(o_round_key_valid),
    .o_key_ready      (o_key_ready),
    .o_byte_count     (o_byte_count),
    .o_overrun        (o_overrun),
    .o_checksum_err   (o_checksum_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the key as an array of bytes plus a few flags.
  logic [7:0] m_bytes [16];
  int         m_count;
  bit         m_full, m_locked, m_check, m_over, m_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_key();
    logic [127:0] k;
    for (int i = 0; i < 16; i++) k[8*i +: 8] = m_bytes[i];
    return k;
  endfunction

  function automatic logic [7:0] m_xor();
    logic [7:0] x = '0;
    for (int i = 0; i < 16; i++) x ^= m_bytes[i];
    return x;
  endfunction

  task automatic m_zero();
    for (int i = 0; i < 16; i++) m_bytes[i] = '0;
  endtask

  task automatic model_step(input bit rst, input bit bv, input logic [7:0] b,
                            input bit clr, input bit calc);
    m_err = 1'b0;
    if (rst) begin
      m_zero(); m_count = 0; m_full = 0; m_locked = 0; m_check = 0; m_over = 0;
    end else if (m_locked) begin
      if (bv) m_over = 1;
      if (!calc) m_locked = 0;
    end else if (clr) begin
      m_zero(); m_count = 0; m_full = 0; m_check = 0; m_over = 0;
    end else if (m_check) begin
      if (bv) begin
        m_check = 0;
        if (b == m_xor()) m_full = 1;
        else begin m_zero(); m_count = 0; m_err = 1; end
      end
    end else if (m_full && calc) begin
      m_locked = 1;
      if (bv) m_over = 1;
    end else if (bv) begin
      if (m_full) begin
        m_full = 0;
        if (CLR) m_zero();
        m_bytes[0] = b;
        m_count = 1;
      end else begin
        m_bytes[m_count] = b;
        m_count++;
        if (m_count == 16) begin
`ifdef TEA_KEY_CHECKSUM_EN
          m_check = 1;
`else
          m_full = 1;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit bv, input logic [7:0] b,
                       input bit clr, input bit calc);
    i_rst_n          = !rst;
    i_key_byte_valid = bv;
    i_key_byte       = b;
    i_key_clear      = clr;
    i_calculate      = calc;
    @(posedge i_clk);
    #1;
    model_step(rst, bv, b, clr, calc);
    check("data",     o_round_key_data,  m_key());
    check("valid",    o_round_key_valid, m_full);
    check("ready",    o_key_ready,       !m_locked);
    check("count",    o_byte_count,      m_count);
    check("overrun",  o_overrun,         m_over);
    check("chk_err",  o_checksum_err,    m_err);
  endtask

  task automatic load_seq();
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, 0);
`ifdef TEA_KEY_CHECKSUM_EN
    cycle(0, 1, 8'h00, 0, 0);
`endif
  endtask

  initial begin
    m_zero(); m_count = 0; m_full = 0; m_locked = 0; m_check = 0; m_over = 0; m_err = 0;

    // Reset state.
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 1, 8'h12, 0, 1);
    check("rst_ready", o_key_ready, 1'b1);
    check("rst_count", o_byte_count, 5'd0);

    // Sequential key 0x00..0x0F.
    load_seq();
    check("seq_word0", o_round_key_data[0], 32'h03020100);
    check("seq_word3", o_round_key_data[3], 32'h0F0E0D0C);
    check("seq_valid", o_round_key_valid, 1'b1);
    check("seq_count", o_byte_count, 5'd16);

    // Lock with a colliding byte: byte dropped, overrun set.
    cycle(0, 1, 8'hAA, 0, 1);
    check("lock_ready",   o_key_ready, 1'b0);
    check("lock_overrun", o_overrun, 1'b1);
    check("lock_word0",   o_round_key_data[0], 32'h03020100);
    cycle(0, 1, 8'hBB, 1, 1);   // clear ignored while locked
    check("lock_clr_cnt", o_byte_count, 5'd16);
    cycle(0, 0, 8'h00, 0, 0);
    check("unlock_ready", o_key_ready, 1'b1);
    check("unlock_valid", o_round_key_valid, 1'b1);

    // Reload from a full key.
    cycle(0, 1, 8'h55, 0, 0);
    check("reload_valid", o_round_key_valid, 1'b0);
    check("reload_key",   o_round_key_data, 128'h55);
    check("reload_count", o_byte_count, 5'd1);

    // Ten bytes total, then clear together with a byte.
    for (int i = 0; i < 9; i++) cycle(0, 1, 8'($urandom), 0, 0);
    check("ten_count", o_byte_count, 5'd10);
    cycle(0, 1, 8'h77, 1, 0);
    check("clr_key",   o_round_key_data, 128'h0);
    check("clr_count", o_byte_count, 5'd0);
    check("clr_over",  o_overrun, 1'b0);

`ifdef TEA_KEY_CHECKSUM_EN
    // Bad checksum byte.
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i), 0, 0);
    check("chk_wait_valid", o_round_key_valid, 1'b0);
    check("chk_wait_count", o_byte_count, 5'd16);
    cycle(0, 1, 8'h01, 0, 0);
    check("chk_bad_err", o_checksum_err, 1'b1);
    check("chk_bad_key", o_round_key_data, 128'h0);
    cycle(0, 0, 8'h00, 0, 0);
    check("chk_err_pulse", o_checksum_err, 1'b0);
`endif

    // Reset while locked.
    load_seq();
    cycle(0, 0, 8'h00, 0, 1);
    check("pre_rst_ready", o_key_ready, 1'b0);
    cycle(1, 1, 8'h99, 0, 1);
    check("rst_lock_ready", o_key_ready, 1'b1);
    check("rst_lock_valid", o_round_key_valid, 1'b0);
    check("rst_lock_key",   o_round_key_data, 128'h0);

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) < 7),
            8'($urandom),
            ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 9) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
